// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller for a five-stage pipeline (RUN / MDU_BUSY / MEM_WAIT).
// Define PIPE_CTRL_MDU_EN to build the MDU wait state, its watchdog and the mdu_timeout flag.
module pipe_ctrl #(
  parameter int STALL_CNT_W = 16,
  parameter int MDU_MAX_CYC = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_use_stall,
  input  logic                   jump_id,
  input  logic                   branch_taken_ex,
  input  logic                   mdu_start,
  input  logic                   mdu_done,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  output logic                   pc_we,
  output logic                   if_id_we,
  output logic                   id_ex_we,
  output logic                   ex_mem_we,
  output logic                   mem_wb_we,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_flush,
  output logic                   mem_wb_flush,
  output logic                   mdu_timeout,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [1:0]             state
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MDU_BUSY = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  // dmem_req is the MEM stage's valid and dmem_ready its ready: the access completes in the
  // cycle both are high, so only req without ready holds the pipe.
  logic       mem_stall;
  logic       mdu_begin;
  logic       mdu_fin;
  logic       wd_last;
  logic [1:0] next_state;

  assign mem_stall = dmem_req & ~dmem_ready;

`ifdef PIPE_CTRL_MDU_EN
  localparam int WD_W = $clog2(MDU_MAX_CYC + 1);

  logic [WD_W-1:0] wd_cnt;

  assign mdu_begin = mdu_start & ~mdu_done;
  assign mdu_fin   = mdu_done;
  assign wd_last   = (state == MDU_BUSY) && (wd_cnt == WD_W'(MDU_MAX_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      mdu_timeout <= 1'b0;
    end else begin
      wd_cnt <= (state == MDU_BUSY && next_state == MDU_BUSY) ? wd_cnt + WD_W'(1) : '0;
      if (wd_last && !(mdu_fin && !mem_stall)) mdu_timeout <= 1'b1;
    end
  end
`else
  localparam int MDU_MAX_UNUSED = MDU_MAX_CYC;

  logic mdu_unused;

  assign mdu_unused  = mdu_start ^ mdu_done;
  assign mdu_begin   = 1'b0;
  assign mdu_fin     = 1'b1;
  // Without the MDU the busy state can never be entered; if it ever were, leave at once.
  assign wd_last     = (state == MDU_BUSY);
  assign mdu_timeout = 1'b0;
`endif

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    mem_wb_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    next_state   = state;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
            mem_wb_flush = 1'b1;
            next_state   = MEM_WAIT;
          end else if (mdu_begin) begin
            {pc_we, if_id_we, id_ex_we} = 3'b000;
            ex_mem_flush = 1'b1;
            next_state   = MDU_BUSY;
          end else if (branch_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use_stall) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (jump_id) begin
            if_id_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_stall) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
            mem_wb_flush = 1'b1;
          end else begin
            next_state = RUN;
          end
        end
        MDU_BUSY: begin
          // A pending memory access outranks the MDU wait but does not leave the state.
          if (mem_stall) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
            mem_wb_flush = 1'b1;
          end else if (!mdu_fin) begin
            {pc_we, if_id_we, id_ex_we} = 3'b000;
            ex_mem_flush = 1'b1;
          end
          if ((mdu_fin && !mem_stall) || wd_last) next_state = RUN;
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      if (!pc_we && stall_cnt != {STALL_CNT_W{1'b1}}) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table vectors, directed corner sequences and random traffic against a stage-depth model of pipe_ctrl.
module tb_pipe_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;
  localparam int MAX_CYC = 8;

`ifdef PIPE_CTRL_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  localparam int S_RUN = 0;
  localparam int S_MDU = 1;
  localparam int S_MEM = 2;

  localparam logic [6:0] I_LU  = 7'b1000000;
  localparam logic [6:0] I_JMP = 7'b0100000;
  localparam logic [6:0] I_BR  = 7'b0010000;
  localparam logic [6:0] I_ST  = 7'b0001000;
  localparam logic [6:0] I_DN  = 7'b0000100;
  localparam logic [6:0] I_RQ  = 7'b0000010;
  localparam logic [6:0] I_RDY = 7'b0000001;

  localparam logic [8:0] O_IDLE = 9'b11111_0000;

  // clock / reset
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic             load_use_stall, jump_id, branch_taken_ex, mdu_start, mdu_done, dmem_req, dmem_ready;
  logic             pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic             mdu_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state;

  pipe_ctrl #(.STALL_CNT_W(CNT_W), .MDU_MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_use_stall(load_use_stall), .jump_id(jump_id), .branch_taken_ex(branch_taken_ex),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .mdu_timeout(mdu_timeout), .stall_cnt(stall_cnt), .state(state)
  );

  // scoreboard
  int         n_cmp = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] outs();
    return {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
  endfunction

  // reference model: a stall is "freeze every register before boundary d, bubble into register d"
  int model_mode, model_wd, model_cnt;
  logic model_to;

  function automatic logic [8:0] model_out(input int mode, input logic [6:0] in);
    logic [4:0] we;
    logic [4:1] fl;
    int         depth;
    logic       mem;
    we    = '1;
    fl    = '0;
    depth = 0;
    mem   = in[1] && !in[0];
    if (mem) depth = 4;
    else if (mode == S_MDU) depth = in[2] ? 0 : 3;
    else if (mode == S_RUN) begin
      if (MDU_EN && in[3] && !in[2]) depth = 3;
      else if (in[4]) begin
        fl[1] = 1'b1;
        fl[2] = 1'b1;
      end else if (in[6]) depth = 2;
      else if (in[5]) fl[1] = 1'b1;
    end
    for (int i = 0; i < depth; i++) we[i] = 1'b0;
    if (depth > 0) fl[depth] = 1'b1;
    return {we[0], we[1], we[2], we[3], we[4], fl[1], fl[2], fl[3], fl[4]};
  endfunction

  task automatic model_next(input logic [6:0] in, input logic exp_pc_we);
    logic mem;
    mem = in[1] && !in[0];
    if (!exp_pc_we) model_cnt = (model_cnt >= CNT_MAX) ? CNT_MAX : model_cnt + 1;
    case (model_mode)
      S_RUN: begin
        if (mem) model_mode = S_MEM;
        else if (MDU_EN && in[3] && !in[2]) begin
          model_mode = S_MDU;
          model_wd   = 0;
        end
      end
      S_MEM: if (!mem) model_mode = S_RUN;
      default: begin
        model_wd++;
        if (!mem && in[2]) model_mode = S_RUN;
        else if (model_wd == MAX_CYC) begin
          model_to   = 1'b1;
          model_mode = S_RUN;
        end
      end
    endcase
  endtask

  // drivers
  task automatic drive(input logic [6:0] in);
    {load_use_stall, jump_id, branch_taken_ex, mdu_start, mdu_done, dmem_req, dmem_ready} = in;
  endtask

  task automatic step(input logic [6:0] in, output logic [8:0] act);
    logic [8:0] exp;
    @(negedge clk);
    drive(in);
    #1;
    act = outs();
    exp = model_out(model_mode, in);
    exp_q.push_back(exp);
    chk("model_state", state, model_mode);
    chk("model_stall_cnt", stall_cnt, model_cnt);
    chk("model_timeout", mdu_timeout, model_to);
    chk("model_outputs", act, exp_q.pop_front());
    model_next(in, exp[8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(I_LU | I_BR | I_ST | I_RQ);
    #1;
    chk("rst_outputs", outs(), O_IDLE);
    chk("rst_state", state, S_RUN);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_timeout", mdu_timeout, 0);
    @(negedge clk);
    drive('0);
    rst_n      = 1'b1;
    model_mode = S_RUN;
    model_wd   = 0;
    model_cnt  = 0;
    model_to   = 1'b0;
  endtask

  typedef struct {
    logic [6:0] in;
    logic [8:0] exp;
    string      name;
  } vec_t;

  vec_t       tbl[$];
  logic [8:0] act;
  logic [6:0] rin;

  initial begin
    rst_n = 1'b0;
    drive('0);
    model_mode = S_RUN;
    model_wd   = 0;
    model_cnt  = 0;
    model_to   = 1'b0;

    tbl.push_back('{7'b0,                   O_IDLE,         "tbl_idle"});
    tbl.push_back('{I_LU,                   9'b00111_0100,  "tbl_load_use"});
    tbl.push_back('{I_JMP,                  9'b11111_1000,  "tbl_jump"});
    tbl.push_back('{I_BR,                   9'b11111_1100,  "tbl_branch"});
    tbl.push_back('{I_LU | I_BR,            9'b11111_1100,  "tbl_branch_over_load_use"});
    tbl.push_back('{I_BR | I_JMP,           9'b11111_1100,  "tbl_branch_over_jump"});
    tbl.push_back('{I_LU | I_JMP,           9'b00111_0100,  "tbl_load_use_over_jump"});
    tbl.push_back('{I_RQ,                   9'b00001_0001,  "tbl_mem_wait"});
    tbl.push_back('{I_RQ | I_BR | I_LU,     9'b00001_0001,  "tbl_mem_over_all"});
    tbl.push_back('{I_RQ | I_RDY | I_BR,    9'b11111_1100,  "tbl_mem_ack_branch"});
    tbl.push_back('{I_RDY | I_JMP,          9'b11111_1000,  "tbl_ready_only_jump"});
    tbl.push_back('{I_ST | I_DN | I_BR,     9'b11111_1100,  "tbl_mdu_single_cycle"});
    tbl.push_back('{I_ST,                   MDU_EN ? 9'b00011_0010 : O_IDLE, "tbl_mdu_start"});
    tbl.push_back('{I_ST | I_BR,            MDU_EN ? 9'b00011_0010 : 9'b11111_1100, "tbl_mdu_over_branch"});
    tbl.push_back('{I_ST | I_RQ,            9'b00001_0001,  "tbl_mem_over_mdu"});

    foreach (tbl[i]) begin
      do_reset();
      step(tbl[i].in, act);
      chk(tbl[i].name, act, tbl[i].exp);
    end

    // single load-use bubble
    do_reset();
    step(I_LU, act);
    chk("lu_pc_we", act[8], 0);
    chk("lu_if_id_we", act[7], 0);
    chk("lu_id_ex_flush", act[2], 1);
    step('0, act);
    chk("lu_stall_cnt", stall_cnt, 1);

    // MDU op: start in cycle 5, done in cycle 9
    do_reset();
    for (int cyc = 0; cyc <= 10; cyc++) begin
      rin = (cyc == 5) ? I_ST : ((cyc == 9) ? I_DN : 7'b0);
      step(rin, act);
      chk("mdu_pc_we", act[8], !(MDU_EN && cyc >= 5 && cyc <= 8));
      chk("mdu_state", state, (MDU_EN && cyc >= 6 && cyc <= 9) ? S_MDU : S_RUN);
    end
    chk("mdu_stall_cnt", stall_cnt, MDU_EN ? 4 : 0);

    // memory wait with a branch sitting in EX the whole time
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(I_RQ | I_BR, act);
      chk("memwait_if_id_flush", act[3], 0);
      chk("memwait_id_ex_flush", act[2], 0);
      chk("memwait_ex_mem_flush", act[1], 0);
      chk("memwait_mem_wb_flush", act[0], 1);
      chk("memwait_pc_we", act[8], 0);
    end
    step(I_RQ | I_RDY | I_BR, act);
    chk("memwait_release", act, O_IDLE);
    step(I_BR, act);
    chk("memwait_branch_after", act, 9'b11111_1100);

    // MDU watchdog with mdu_done never arriving
    do_reset();
    step(I_ST, act);
    for (int k = 1; k <= 12; k++) begin
      step('0, act);
      chk("wd_state", state, (MDU_EN && k <= MAX_CYC) ? S_MDU : S_RUN);
      chk("wd_timeout", mdu_timeout, MDU_EN && k > MAX_CYC);
    end

    // stall counter saturates instead of wrapping
    do_reset();
    repeat (20) step(I_LU, act);
    chk("sat_stall_cnt", stall_cnt, CNT_MAX);
    step('0, act);
    chk("sat_stall_cnt_hold", stall_cnt, CNT_MAX);

    // asynchronous reset in the middle of a memory wait
    do_reset();
    step(I_RQ, act);
    step(I_RQ, act);
    chk("async_pre_state", state, S_MEM);
    chk("async_pre_cnt", stall_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", state, S_RUN);
    chk("async_stall_cnt", stall_cnt, 0);
    chk("async_outputs", outs(), O_IDLE);
    @(negedge clk);
    drive('0);
    rst_n      = 1'b1;
    model_mode = S_RUN;
    model_wd   = 0;
    model_cnt  = 0;
    model_to   = 1'b0;
    step('0, act);
    chk("async_after_release", act, O_IDLE);

    // random traffic against the model
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        rin[6] = ($urandom_range(0, 3) == 0);
        rin[5] = ($urandom_range(0, 3) == 0);
        rin[4] = ($urandom_range(0, 4) == 0);
        rin[3] = ($urandom_range(0, 5) == 0);
        rin[2] = ($urandom_range(0, 5) == 0);
        rin[1] = ($urandom_range(0, 2) == 0);
        rin[0] = ($urandom_range(0, 2) != 0);
        step(rin, act);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
